nrf_rx_poll_engine: RTL and testbench



---
 rtl/nrf_rx_poll_engine_if.sv | 25 ++
 rtl/nrf_rx_poll_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_nrf_rx_poll_engine.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nrf_rx_poll_engine_if.sv
// Bus bundle for nrf_rx_poll_engine: SPI byte-master handshake plus the payload byte stream.
// master = engine side, slave = SPI master / downstream side.
interface nrf_rx_poll_engine_if;
    logic       i_TX_Ready;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       o_TX_DV;
    logic [7:0] o_TX_Byte;
    logic       o_SPI_Csn;
    logic [7:0] o_Data;
    logic       o_Valid;
    logic       i_Ready;
    logic       o_Last;
    logic [2:0] o_Pipe;

    modport master (
        input  i_TX_Ready, i_RX_DV, i_RX_Byte, i_Ready,
        output o_TX_DV, o_TX_Byte, o_SPI_Csn, o_Data, o_Valid, o_Last, o_Pipe
    );

    modport slave (
        output i_TX_Ready, i_RX_DV, i_RX_Byte, i_Ready,
        input  o_TX_DV, o_TX_Byte, o_SPI_Csn, o_Data, o_Valid, o_Last, o_Pipe
    );
endinterface

// File: rtl/nrf_rx_poll_engine.sv
// nRF24L01 receive poller: periodic STATUS poll, RX FIFO drain, RX_DR clear and FIFO re-check,
// with payload bytes streamed out through a single-entry valid/ready register.
module nrf_rx_poll_engine #(
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter int unsigned POLL_CYCLES   = 50000,
    parameter int unsigned CSN_GAP       = 2,
    parameter int unsigned MAX_PKTS      = 3
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Enable,
    nrf_rx_poll_engine_if.master bus,
    output logic                 o_Busy,
    output logic [15:0]          o_Pkt_Count
);

    typedef enum logic [2:0] {ST_WAIT, ST_STAT, ST_PAYLOAD, ST_CLR, ST_FIFO, ST_GAP} state_t;
    typedef enum logic [1:0] {PH_START, PH_ISSUE, PH_WAIT_RX} phase_t;

    localparam int unsigned CNT_W = $clog2(POLL_CYCLES);
    localparam int unsigned IDX_W = $clog2(PAYLOAD_BYTES + 2);
    localparam int unsigned GAP_W = (CSN_GAP > 1) ? $clog2(CSN_GAP) : 1;

    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CSN_GAP - 1);
    localparam logic [IDX_W-1:0] PAY_LAST  = IDX_W'(PAYLOAD_BYTES);
    localparam logic [1:0]       PKT_MAX   = 2'(MAX_PKTS);

    state_t           state_q, state_d;
    state_t           next_q, next_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       pkts_q, pkts_d;
    logic [2:0]       pend_q, pend_d;
    logic             csn_q, csn_d;
    logic             tx_dv_q, tx_dv_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [2:0]       pipe_q, pipe_d;
    logic             busy_q, busy_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    logic [7:0]       cmd_byte;
    logic [IDX_W-1:0] last_idx;
    logic             accept;
    logic             can_issue;

    // Byte to send and index of the final byte for the current transaction.
    always_comb begin
        cmd_byte = 8'hFF;
        last_idx = '0;
        case (state_q)
            ST_PAYLOAD: begin
                cmd_byte = (idx_q == '0) ? 8'h61 : 8'hFF;
                last_idx = PAY_LAST;
            end
            ST_CLR: begin
                cmd_byte = (idx_q == '0) ? 8'h27 : 8'h40;
                last_idx = IDX_W'(1);
            end
            ST_FIFO: begin
                cmd_byte = (idx_q == '0) ? 8'h17 : 8'hFF;
                last_idx = IDX_W'(1);
            end
            default: ;
        endcase
    end

    assign accept = valid_q && bus.i_Ready;
    // Payload data strobes wait for room in the output register; CSN stays low meanwhile.
    assign can_issue = bus.i_TX_Ready &&
                       (state_q != ST_PAYLOAD || idx_q == '0 || !valid_q || bus.i_Ready);

    always_comb begin
        state_d     = state_q;
        next_d      = next_q;
        phase_d     = phase_q;
        cnt_d       = '0;
        gap_d       = gap_q;
        idx_d       = idx_q;
        pkts_d      = pkts_q;
        pend_d      = pend_q;
        csn_d       = csn_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        data_d      = data_q;
        valid_d     = valid_q && !accept;
        last_d      = last_q;
        pipe_d      = pipe_q;
        pkt_count_d = (accept && last_q) ? pkt_count_q + 1'b1 : pkt_count_q;

        case (state_q)
            ST_WAIT: begin
                csn_d = 1'b1;
                if (cnt_q == POLL_LAST) begin
                    cnt_d = cnt_q;
                    if (i_Enable) begin
                        cnt_d   = '0;
                        state_d = ST_STAT;
                        phase_d = PH_START;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = next_q;
                    phase_d = PH_START;
                    idx_d   = '0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                case (phase_q)
                    PH_START: begin
                        csn_d   = 1'b0;
                        phase_d = PH_ISSUE;
                    end
                    PH_ISSUE: begin
                        if (can_issue) begin
                            tx_dv_d   = 1'b1;
                            tx_byte_d = cmd_byte;
                            phase_d   = PH_WAIT_RX;
                        end
                    end
                    default: begin
                        if (bus.i_RX_DV) begin
                            idx_d   = idx_q + 1'b1;
                            phase_d = PH_ISSUE;
                            // Byte returned with the read command is STATUS; it supplies the pipe tag.
                            if (state_q == ST_PAYLOAD) begin
                                if (idx_q == '0) begin
                                    pend_d = bus.i_RX_Byte[3:1];
                                end else begin
                                    data_d  = bus.i_RX_Byte;
                                    valid_d = 1'b1;
                                    last_d  = (idx_q == PAY_LAST);
                                    pipe_d  = pend_q;
                                end
                            end
                            if (idx_q == last_idx) begin
                                csn_d   = 1'b1;
                                state_d = ST_GAP;
                                gap_d   = '0;
                                case (state_q)
                                    ST_STAT: begin
                                        if (bus.i_RX_Byte[6] && bus.i_RX_Byte[3:1] != 3'b111) begin
                                            next_d = ST_PAYLOAD;
                                            pend_d = bus.i_RX_Byte[3:1];
                                            pkts_d = '0;
                                        end else begin
                                            next_d = ST_WAIT;
                                        end
                                    end
                                    ST_PAYLOAD: begin
                                        next_d = ST_CLR;
                                        pkts_d = pkts_q + 1'b1;
                                    end
                                    ST_CLR:  next_d = ST_FIFO;
                                    ST_FIFO: next_d = (!bus.i_RX_Byte[0] && pkts_q < PKT_MAX)
                                                      ? ST_PAYLOAD : ST_WAIT;
                                    default: next_d = ST_WAIT;
                                endcase
                            end
                        end
                    end
                endcase
            end
        endcase

        busy_d = (state_d != ST_WAIT);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= ST_WAIT;
            next_q      <= ST_WAIT;
            phase_q     <= PH_START;
            cnt_q       <= '0;
            gap_q       <= '0;
            idx_q       <= '0;
            pkts_q      <= '0;
            pend_q      <= '0;
            csn_q       <= 1'b1;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= 8'hFF;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            pipe_q      <= '0;
            busy_q      <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            next_q      <= next_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            idx_q       <= idx_d;
            pkts_q      <= pkts_d;
            pend_q      <= pend_d;
            csn_q       <= csn_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            pipe_q      <= pipe_d;
            busy_q      <= busy_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign bus.o_SPI_Csn = csn_q;
    assign bus.o_TX_DV   = tx_dv_q;
    assign bus.o_TX_Byte = tx_byte_q;
    assign bus.o_Data    = data_q;
    assign bus.o_Valid   = valid_q;
    assign bus.o_Last    = last_q;
    assign bus.o_Pipe    = pipe_q;
    assign o_Busy        = busy_q;
    assign o_Pkt_Count   = pkt_count_q;

endmodule

// File: tb/tb_nrf_rx_poll_engine.sv
// Bench for nrf_rx_poll_engine: behavioural nRF24L01 + SPI master model, table of poll scenarios,
// plus hand-written downstream-stall and mid-packet reset sequences.
`timescale 1ns/1ps
module tb_nrf_rx_poll_engine;
    localparam int unsigned PB = 4;
    localparam int unsigned PC = 16;
    localparam int unsigned CG = 2;
    localparam int unsigned MP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        busy;
    logic [15:0] pkt_count;

    nrf_rx_poll_engine_if bus();

    nrf_rx_poll_engine #(
        .PAYLOAD_BYTES(PB),
        .POLL_CYCLES  (PC),
        .CSN_GAP      (CG),
        .MAX_PKTS     (MP)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Enable   (enable),
        .bus        (bus),
        .o_Busy     (busy),
        .o_Pkt_Count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [2:0] p;
    } got_t;

    typedef struct {
        logic [7:0]  status;
        logic [7:0]  fifo;
        int unsigned pkts;
        int unsigned mosi;
        logic [2:0]  pipe;
    } vec_t;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0]  status_cfg = 8'h0E;
    logic [7:0]  fifo_cfg   = 8'h11;
    logic [7:0]  pay_base [4];
    logic [7:0]  pay_q [$];
    logic [7:0]  mosi_log [$];
    got_t        got_q [$];
    int unsigned low_run = 0;
    int unsigned last_low_run = 0;
    int unsigned high_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int unsigned budget, input string name);
        int unsigned n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== lvl) begin
            errors++;
            $display("FAIL %s: o_Busy=%0b after %0d cycles, expected %0b", name, busy, n, lvl);
        end
    endtask

    task automatic prep(input logic [7:0] st, input logic [7:0] ff);
        status_cfg = st;
        fifo_cfg   = ff;
        pay_q.delete();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++)
                pay_q.push_back(pay_base[i] + 8'(k));
        mosi_log.delete();
        got_q.delete();
    endtask

    function automatic logic [7:0] exp_mosi(input int unsigned i);
        if (i == 0) return 8'hFF;
        case ((i - 1) % 9)
            0:       return 8'h61;
            5:       return 8'h27;
            6:       return 8'h40;
            7:       return 8'h17;
            default: return 8'hFF;
        endcase
    endfunction

    // nRF24L01 behind an SPI byte master: 3-cycle turnaround per byte.
    initial begin : spi_model
        int unsigned tidx;
        logic [7:0]  cmd;
        logic [7:0]  resp;
        tidx = 0;
        cmd  = 8'h00;
        bus.i_TX_Ready = 1'b1;
        bus.i_RX_DV    = 1'b0;
        bus.i_RX_Byte  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.i_RX_DV = 1'b0;
            if (bus.o_SPI_Csn) tidx = 0;
            if (bus.o_TX_DV) begin
                check("strobe_csn_low", 32'(bus.o_SPI_Csn), 32'd0);
                mosi_log.push_back(bus.o_TX_Byte);
                if (tidx == 0) begin
                    cmd  = bus.o_TX_Byte;
                    resp = status_cfg;
                end else if (cmd == 8'h61) begin
                    if (pay_q.size() != 0) resp = pay_q.pop_front();
                    else resp = 8'h00;
                end else if (cmd == 8'h17) begin
                    resp = fifo_cfg;
                end else begin
                    resp = status_cfg;
                end
                tidx++;
                bus.i_TX_Ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.i_RX_DV    = 1'b1;
                bus.i_RX_Byte  = resp;
                bus.i_TX_Ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.o_Valid && bus.i_Ready)
            got_q.push_back({bus.o_Data, bus.o_Last, bus.o_Pipe});
        if (rst) low_run = 0;
        else if (!busy) low_run++;
        else if (low_run != 0) begin
            last_low_run = low_run;
            low_run = 0;
        end
        if (bus.o_SPI_Csn) begin
            high_run++;
        end else begin
            if (high_run != 0) begin
                checks++;
                if (high_run < CG) begin
                    errors++;
                    $display("FAIL csn_gap: high for %0d cycles, need >= %0d", high_run, CG);
                end
            end
            high_run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t        vecs [6];
        logic [15:0] cnt0;
        int unsigned n;
        int unsigned s_strobe, s_csn, s_data, s_valid;
        logic [7:0]  exp_stream [4];

        pay_base[0] = 8'hDE; pay_base[1] = 8'hAD; pay_base[2] = 8'hBE; pay_base[3] = 8'hEF;
        vecs[0] = '{8'h0E, 8'h11, 0, 1,  3'd0};
        vecs[1] = '{8'h42, 8'h11, 1, 10, 3'd1};
        vecs[2] = '{8'h4E, 8'h11, 0, 1,  3'd0};
        vecs[3] = '{8'h4A, 8'h10, 3, 28, 3'd5};
        vecs[4] = '{8'h40, 8'h01, 1, 10, 3'd0};
        vecs[5] = '{8'h0C, 8'h10, 0, 1,  3'd0};
        bus.i_Ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_csn",     32'(bus.o_SPI_Csn), 32'd1);
        check("rst_tx_dv",   32'(bus.o_TX_DV),   32'd0);
        check("rst_tx_byte", 32'(bus.o_TX_Byte), 32'hFF);
        check("rst_data",    32'(bus.o_Data),    32'd0);
        check("rst_valid",   32'(bus.o_Valid),   32'd0);
        check("rst_last",    32'(bus.o_Last),    32'd0);
        check("rst_pipe",    32'(bus.o_Pipe),    32'd0);
        check("rst_busy",    32'(busy),          32'd0);
        check("rst_pkt_cnt", 32'(pkt_count),     32'd0);
        rst    = 1'b0;
        enable = 1'b1;

        for (int v = 0; v < 6; v++) begin
            prep(vecs[v].status, vecs[v].fifo);
            cnt0 = pkt_count;
            wait_busy(1'b1, 200, "poll_start");
            #1;
            check("poll_interval", last_low_run, PC);
            wait_busy(1'b0, 3000, "poll_end");
            repeat (2) @(negedge clk);
            check("mosi_count", mosi_log.size(), vecs[v].mosi);
            for (int i = 0; i < mosi_log.size() && i < vecs[v].mosi; i++)
                check("mosi_byte", 32'(mosi_log[i]), 32'(exp_mosi(i)));
            check("byte_count", got_q.size(), vecs[v].pkts * PB);
            for (int j = 0; j < got_q.size() && j < vecs[v].pkts * PB; j++) begin
                check("data", 32'(got_q[j].d), 32'(pay_base[j % 4] + 8'(j / 4)));
                check("last", 32'(got_q[j].l), 32'((j % 4) == 3));
                check("pipe", 32'(got_q[j].p), 32'(vecs[v].pipe));
            end
            check("pkt_count", 32'(pkt_count), 32'(cnt0 + 16'(vecs[v].pkts)));
            check("valid_idle", 32'(bus.o_Valid), 32'd0);
        end

        // Downstream stall on the first payload byte.
        prep(8'h42, 8'h11);
        cnt0 = pkt_count;
        bus.i_Ready = 1'b0;
        wait_busy(1'b1, 200, "stall_poll_start");
        n = 0;
        while (bus.o_Valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", 32'(bus.o_Valid), 32'd1);
        s_strobe = 0; s_csn = 0; s_data = 0; s_valid = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.o_TX_DV)          s_strobe++;
            if (bus.o_SPI_Csn)        s_csn++;
            if (bus.o_Data !== 8'hDE) s_data++;
            if (!bus.o_Valid)         s_valid++;
        end
        check("stall_strobes", s_strobe, 0);
        check("stall_csn_high", s_csn, 0);
        check("stall_data_moved", s_data, 0);
        check("stall_valid_drop", s_valid, 0);
        @(posedge clk);
        #1;
        bus.i_Ready = 1'b1;
        wait_busy(1'b0, 3000, "stall_poll_end");
        repeat (2) @(negedge clk);
        exp_stream[0] = 8'hDE; exp_stream[1] = 8'hAD; exp_stream[2] = 8'hBE; exp_stream[3] = 8'hEF;
        check("stall_byte_count", got_q.size(), 4);
        for (int j = 0; j < got_q.size() && j < 4; j++) begin
            check("stall_data", 32'(got_q[j].d), 32'(exp_stream[j]));
            check("stall_last", 32'(got_q[j].l), 32'(j == 3));
            check("stall_pipe", 32'(got_q[j].p), 32'd1);
        end
        check("stall_pkt_count", 32'(pkt_count), 32'(cnt0 + 16'd1));

        // Reset after the second payload byte.
        prep(8'h42, 8'h11);
        wait_busy(1'b1, 200, "rst_poll_start");
        n = 0;
        while (got_q.size() < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_two_bytes", got_q.size(), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_csn",     32'(bus.o_SPI_Csn), 32'd1);
        check("midrst_valid",   32'(bus.o_Valid),   32'd0);
        check("midrst_pkt_cnt", 32'(pkt_count),     32'd0);
        check("midrst_busy",    32'(busy),          32'd0);
        rst = 1'b0;
        status_cfg = 8'h0E;
        mosi_log.delete();
        got_q.delete();
        wait_busy(1'b1, 200, "after_rst_poll_start");
        #1;
        check("after_rst_interval", last_low_run, PC);
        wait_busy(1'b0, 3000, "after_rst_poll_end");
        repeat (2) @(negedge clk);
        check("after_rst_mosi_count", mosi_log.size(), 1);
        if (mosi_log.size() != 0)
            check("after_rst_nop", 32'(mosi_log[0]), 32'hFF);
        check("after_rst_bytes", got_q.size(), 0);
        check("after_rst_pkt_cnt", 32'(pkt_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
